// File: rtl/blk_scan_gen.sv
// ---------------------------------------------------------------------------
// blk_scan_gen
//
// Walks a WIDTH x LENGTH luma frame in BLK x BLK blocks and presents one
// packed {row, col} pixel address per valid/ready handshake to the
// intra-prediction loop.  Three scan orders are supported:
//   mode 0 (and 3) : plain raster over blocks
//   mode 1         : macroblock raster, blocks inside each MB in raster order
//   mode 2         : macroblock raster, blocks inside each MB in H.264 z-order
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   enable     in   global advance enable; low freezes every register
//   start      in   begin a frame scan (honoured in IDLE only)
//   mode       in   scan order, latched at start
//   out_valid  out  mbnumber / blk_index / flags are valid
//   out_ready  in   consumer accepts the current address
//   mbnumber   out  {row, col}, row in the upper COORD_W bits, pixel units
//   blk_index  out  sequence number of the current address, from 0
//   first_blk  out  current address is the first of the frame
//   last_blk   out  current address is the last of the frame
//   busy       out  scan in progress
//   done       out  one-cycle pulse after the last handshake
// ---------------------------------------------------------------------------
module blk_scan_gen #(
    parameter int WIDTH   = 720,
    parameter int LENGTH  = 1280,
    parameter int BLK     = 4,
    parameter int MB      = 16,
    parameter int COORD_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*COORD_W-1:0]   mbnumber,
    output logic [31:0]            blk_index,
    output logic                   first_blk,
    output logic                   last_blk,
    output logic                   busy,
    output logic                   done
);

    localparam int                 BLK_SH      = $clog2(BLK);
    localparam logic [COORD_W-1:0] C_ZERO      = {COORD_W{1'b0}};
    localparam logic [COORD_W-1:0] C_BLK       = COORD_W'(BLK);
    localparam logic [COORD_W-1:0] C_MB        = COORD_W'(MB);
    localparam logic [COORD_W-1:0] C_COL_LAST  = COORD_W'(WIDTH - BLK);
    localparam logic [COORD_W-1:0] C_MBCOL_LAST = COORD_W'(WIDTH - MB);
    localparam logic [31:0]        C_LAST_IDX  = 32'((WIDTH / BLK) * (LENGTH / BLK) - 1);

    localparam logic [1:0] MODE_RASTER = 2'd0;
    localparam logic [1:0] MODE_ZORDER = 2'd2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Maps a 4-bit sub-block index inside an MB to {y[1:0], x[1:0]}.
    // z-order interleaves the index bits: x = {i2, i0}, y = {i3, i1}.
    function automatic logic [3:0] sub_to_yx(input logic [1:0] scan_mode,
                                             input logic [3:0] idx);
        logic [3:0] yx;
        if (scan_mode == MODE_ZORDER) begin
            yx = {idx[3], idx[1], idx[2], idx[0]};
        end else begin
            yx = idx;
        end
        return yx;
    endfunction

    // Registered state
    state_t             r_state;
    logic [1:0]         r_mode;
    logic               r_valid;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_mb_row;
    logic [COORD_W-1:0] r_mb_col;
    logic [3:0]         r_sub;
    logic [31:0]        r_index;
    logic               r_first;
    logic               r_last;
    logic               r_busy;
    logic               r_done;

    // Next-state values
    state_t             w_state_nxt;
    logic [1:0]         w_mode_nxt;
    logic               w_valid_nxt;
    logic [COORD_W-1:0] w_row_nxt;
    logic [COORD_W-1:0] w_col_nxt;
    logic [COORD_W-1:0] w_mb_row_nxt;
    logic [COORD_W-1:0] w_mb_col_nxt;
    logic [3:0]         w_sub_nxt;
    logic [31:0]        w_index_nxt;
    logic               w_first_nxt;
    logic               w_last_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    // Advance candidates
    logic               w_hs;
    logic [3:0]         w_sub_adv;
    logic [COORD_W-1:0] w_mb_row_adv;
    logic [COORD_W-1:0] w_mb_col_adv;
    logic [3:0]         w_yx_adv;
    logic [COORD_W-1:0] w_row_adv;
    logic [COORD_W-1:0] w_col_adv;
    logic [31:0]        w_index_adv;

    assign w_hs        = r_valid & out_ready & enable;
    assign w_index_adv = r_index + 32'd1;

    // Next block address after the current one, for the latched scan order
    always_comb begin
        w_sub_adv    = r_sub + 4'd1;
        w_mb_row_adv = r_mb_row;
        w_mb_col_adv = r_mb_col;
        w_row_adv    = r_row;
        w_col_adv    = r_col;

        // MB origin steps only when the sub index wraps past 15
        if (r_sub == 4'd15) begin
            if (r_mb_col == C_MBCOL_LAST) begin
                w_mb_col_adv = C_ZERO;
                w_mb_row_adv = r_mb_row + C_MB;
            end else begin
                w_mb_col_adv = r_mb_col + C_MB;
            end
        end else begin
            w_mb_col_adv = r_mb_col;
        end

        w_yx_adv = sub_to_yx(r_mode, w_sub_adv);

        if (r_mode == MODE_RASTER) begin
            if (r_col == C_COL_LAST) begin
                w_col_adv = C_ZERO;
                w_row_adv = r_row + C_BLK;
            end else begin
                w_col_adv = r_col + C_BLK;
                w_row_adv = r_row;
            end
        end else begin
            w_row_adv = w_mb_row_adv + ({{(COORD_W-2){1'b0}}, w_yx_adv[3:2]} << BLK_SH);
            w_col_adv = w_mb_col_adv + ({{(COORD_W-2){1'b0}}, w_yx_adv[1:0]} << BLK_SH);
        end
    end

    // FSM next-state and output values
    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_valid_nxt  = r_valid;
        w_row_nxt    = r_row;
        w_col_nxt    = r_col;
        w_mb_row_nxt = r_mb_row;
        w_mb_col_nxt = r_mb_col;
        w_sub_nxt    = r_sub;
        w_index_nxt  = r_index;
        w_first_nxt  = r_first;
        w_last_nxt   = r_last;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped so the
                // consumer always sees at least one idle cycle between frames.
                if (start && !r_done) begin
                    w_state_nxt  = ST_RUN;
                    w_mode_nxt   = (mode == 2'd3) ? MODE_RASTER : mode;
                    w_valid_nxt  = 1'b1;
                    w_busy_nxt   = 1'b1;
                    w_row_nxt    = C_ZERO;
                    w_col_nxt    = C_ZERO;
                    w_mb_row_nxt = C_ZERO;
                    w_mb_col_nxt = C_ZERO;
                    w_sub_nxt    = 4'd0;
                    w_index_nxt  = 32'd0;
                    w_first_nxt  = 1'b1;
                    w_last_nxt   = (C_LAST_IDX == 32'd0);
                end else begin
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_hs) begin
                    if (r_last) begin
                        // Address and index keep their final values
                        w_state_nxt = ST_IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_first_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_row_nxt    = w_row_adv;
                        w_col_nxt    = w_col_adv;
                        w_mb_row_nxt = w_mb_row_adv;
                        w_mb_col_nxt = w_mb_col_adv;
                        w_sub_nxt    = w_sub_adv;
                        w_index_nxt  = w_index_adv;
                        w_first_nxt  = 1'b0;
                        w_last_nxt   = (w_index_adv == C_LAST_IDX);
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_first_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; enable low freezes everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= 2'd0;
            r_valid  <= 1'b0;
            r_row    <= C_ZERO;
            r_col    <= C_ZERO;
            r_mb_row <= C_ZERO;
            r_mb_col <= C_ZERO;
            r_sub    <= 4'd0;
            r_index  <= 32'd0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (enable) begin
            r_state  <= w_state_nxt;
            r_mode   <= w_mode_nxt;
            r_valid  <= w_valid_nxt;
            r_row    <= w_row_nxt;
            r_col    <= w_col_nxt;
            r_mb_row <= w_mb_row_nxt;
            r_mb_col <= w_mb_col_nxt;
            r_sub    <= w_sub_nxt;
            r_index  <= w_index_nxt;
            r_first  <= w_first_nxt;
            r_last   <= w_last_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign out_valid = r_valid;
    assign mbnumber  = {r_row, r_col};
    assign blk_index = r_index;
    assign first_blk = r_first;
    assign last_blk  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_blk_scan_gen.sv
// ---------------------------------------------------------------------------
// tb_blk_scan_gen
//
// Scoreboard bench for blk_scan_gen.  Stimulus pushes the expected address
// stream (closed-form model of each scan order) into a queue; a monitor pops
// and compares on every handshake and also checks hold-while-stalled, the
// done pulse and hand-computed anchor addresses.  Two instances: full size
// (720x1280) and reduced (32x16).
// ---------------------------------------------------------------------------
module tb_blk_scan_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enable, start, s_start, out_ready;
    logic [1:0] mode;

    logic        b_valid, b_first, b_last, b_busy, b_done;
    logic [31:0] b_mb, b_ix;
    logic        s_valid, s_first, s_last, s_busy, s_done;
    logic [31:0] s_mb, s_ix;

    blk_scan_gen u_big (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
        .out_valid(b_valid), .out_ready(out_ready), .mbnumber(b_mb),
        .blk_index(b_ix), .first_blk(b_first), .last_blk(b_last),
        .busy(b_busy), .done(b_done)
    );

    blk_scan_gen #(.WIDTH(32), .LENGTH(16)) u_small (
        .clk(clk), .reset(reset), .enable(enable), .start(s_start), .mode(mode),
        .out_valid(s_valid), .out_ready(out_ready), .mbnumber(s_mb),
        .blk_index(s_ix), .first_blk(s_first), .last_blk(s_last),
        .busy(s_busy), .done(s_done)
    );

    logic [1:0]  v_a, f_a, l_a, bz_a, d_a;
    logic [31:0] mb_a [2];
    logic [31:0] ix_a [2];
    assign v_a  = {s_valid, b_valid};
    assign f_a  = {s_first, b_first};
    assign l_a  = {s_last,  b_last};
    assign bz_a = {s_busy,  b_busy};
    assign d_a  = {s_done,  b_done};
    assign mb_a[0] = b_mb;
    assign mb_a[1] = s_mb;
    assign ix_a[0] = b_ix;
    assign ix_a[1] = s_ix;

    typedef struct {
        int          k;
        logic [31:0] mb;
        logic [31:0] idx;
        logic        first;
        logic        last;
    } exp_t;

    exp_t        q[$];
    logic [31:0] hand [int];
    int          checks = 0;
    int          errors = 0;
    int          hs_cnt [2];
    int          done_cnt [2];
    logic [1:0]  exp_done = 2'b00;
    logic [1:0]  stall_arm = 2'b00;
    logic [66:0] saved [2];
    logic [31:0] last_mb [2];
    logic [31:0] last_ix [2];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Closed-form address of the n-th block for frame width w
    function automatic logic [31:0] model_mb(input int md, input int n, input int w);
        int row, col, mbn, sub, x, y;
        if (md == 1 || md == 2) begin
            mbn = n / 16;
            sub = n % 16;
            if (md == 1) begin
                x = sub % 4;
                y = sub / 4;
            end else begin
                x = ((sub >> 2) & 1) * 2 + (sub & 1);
                y = ((sub >> 3) & 1) * 2 + ((sub >> 1) & 1);
            end
            row = (mbn / (w / 16)) * 16 + y * 4;
            col = (mbn % (w / 16)) * 16 + x * 4;
        end else begin
            row = (n / (w / 4)) * 4;
            col = (n % (w / 4)) * 4;
        end
        return {16'(row), 16'(col)};
    endfunction

    task automatic push_exp(input int k, input int md, input int count, input int total, input int w);
        exp_t e;
        for (int n = 0; n < count; n++) begin
            e.k     = k;
            e.mb    = model_mb(md, n, w);
            e.idx   = 32'(n);
            e.first = (n == 0);
            e.last  = (n == total - 1);
            q.push_back(e);
        end
    endtask

    task automatic sethand(input int idx, input logic [15:0] r, input logic [15:0] c);
        hand[idx] = {r, c};
    endtask

    // Monitor: handshake scoreboard, stall stability, done pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (exp_done[k]) begin
                    exp_done[k] = 1'b0;
                    chk("done_pulse", 96'({d_a[k], v_a[k], bz_a[k]}), 96'(3'b100));
                    chk("final_hold", 96'({mb_a[k], ix_a[k]}), 96'({last_mb[k], last_ix[k]}));
                end else if (d_a[k] === 1'b1) begin
                    chk("stray_done", 96'(d_a[k]), 96'd0);
                end
                if (d_a[k] === 1'b1) done_cnt[k]++;
                if (v_a[k] !== 1'b1 && (f_a[k] === 1'b1 || l_a[k] === 1'b1))
                    chk("flag_without_valid", 96'({f_a[k], l_a[k]}), 96'd0);
                if (stall_arm[k])
                    chk("stall_hold", 96'({v_a[k], f_a[k], l_a[k], mb_a[k], ix_a[k]}), 96'(saved[k]));
                stall_arm[k] = (v_a[k] === 1'b1) && !(out_ready && enable) && !reset;
                saved[k]     = {v_a[k], f_a[k], l_a[k], mb_a[k], ix_a[k]};
                if (v_a[k] === 1'b1 && out_ready && enable && !reset) begin
                    hs_cnt[k]++;
                    if (q.size() == 0) begin
                        chk("unexpected_handshake", 96'(ix_a[k]), 96'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        chk("instance", 96'(k), 96'(e.k));
                        chk("mbnumber", 96'(mb_a[k]), 96'(e.mb));
                        chk("blk_index", 96'(ix_a[k]), 96'(e.idx));
                        chk("first_last_busy", 96'({f_a[k], l_a[k], bz_a[k]}), 96'({e.first, e.last, 1'b1}));
                        if (hand.exists(int'(e.idx)))
                            chk("anchor_addr", 96'(mb_a[k]), 96'(hand[int'(e.idx)]));
                        if (e.last) begin
                            exp_done[k] = 1'b1;
                            last_mb[k]  = e.mb;
                            last_ix[k]  = e.idx;
                        end
                    end
                end
            end
        end
    end

    // Partial scan on the big instance, then reset mid-scan
    task automatic run_partial(input int md, input int count);
        int i;
        push_exp(0, md, count, 57600, 720);
        out_ready = 1'b1;
        mode      = 2'(md);
        start     = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        while (q.size() != 0 && i < 5000) begin
            if (i == 50) begin
                start = 1'b1;
                mode  = (md == 1) ? 2'd2 : 2'd1;
            end else begin
                start = 1'b0;
                mode  = 2'(md);
            end
            tick();
            i++;
        end
        start = 1'b0;
        mode  = 2'(md);
        if (q.size() != 0) chk("partial_timeout", 96'(q.size()), 96'd0);
        chk("index_before_reset", 96'(b_ix), 96'(count));
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        chk("reset_mid_scan", 96'({b_valid, b_first, b_last, b_busy, b_done, b_mb, b_ix}), 96'd0);
        reset = 1'b0;
        q.delete();
        hand.delete();
        tick();
    endtask

    initial begin
        int i;
        reset = 1'b1; enable = 1'b1; start = 1'b0; s_start = 1'b0;
        out_ready = 1'b0; mode = 2'd0;
        hs_cnt[0] = 0; hs_cnt[1] = 0; done_cnt[0] = 0; done_cnt[1] = 0;
        repeat (3) tick();
        chk("reset_big", 96'({b_valid, b_first, b_last, b_busy, b_done, b_mb, b_ix}), 96'd0);
        chk("reset_small", 96'({s_valid, s_first, s_last, s_busy, s_done, s_mb, s_ix}), 96'd0);
        reset = 1'b0;
        tick();

        // Raster, reset at blk_index 100
        sethand(1, 16'd0, 16'd4);
        run_partial(0, 100);

        // Restart with mode 3 behaves as raster
        sethand(1, 16'd0, 16'd4);    sethand(179, 16'd0, 16'd716);
        sethand(180, 16'd4, 16'd0);
        run_partial(3, 200);

        // MB-raster
        sethand(1, 16'd0, 16'd4);    sethand(2, 16'd0, 16'd8);
        sethand(3, 16'd0, 16'd12);   sethand(4, 16'd4, 16'd0);
        sethand(15, 16'd12, 16'd12); sethand(16, 16'd0, 16'd16);
        sethand(720, 16'd16, 16'd0);
        run_partial(1, 721);

        // z-order
        sethand(1, 16'd0, 16'd4);    sethand(2, 16'd4, 16'd0);
        sethand(3, 16'd4, 16'd4);    sethand(4, 16'd0, 16'd8);
        sethand(5, 16'd0, 16'd12);   sethand(6, 16'd4, 16'd8);
        sethand(7, 16'd4, 16'd12);   sethand(8, 16'd8, 16'd0);
        sethand(16, 16'd0, 16'd16);
        run_partial(2, 17);

        // Reduced frame, z-order, start held high across two frames
        sethand(2, 16'd4, 16'd0); sethand(16, 16'd0, 16'd16); sethand(31, 16'd12, 16'd28);
        push_exp(1, 2, 32, 32, 32);
        push_exp(1, 2, 32, 32, 32);
        hs_cnt[1] = 0; done_cnt[1] = 0;
        mode = 2'd2; out_ready = 1'b1; s_start = 1'b1;
        i = 0;
        while (done_cnt[1] == 0 && i < 500) begin tick(); i++; end
        chk("small_done_seen", 96'(done_cnt[1]), 96'd1);
        chk("start_in_done_ignored", 96'(s_valid), 96'd0);
        tick();
        chk("restart_after_done", 96'({s_valid, s_first, s_ix}), 96'({1'b1, 1'b1, 32'd0}));
        s_start = 1'b0;
        i = 0;
        while (done_cnt[1] < 2 && i < 500) begin tick(); i++; end
        repeat (4) tick();
        chk("small_handshakes", 96'(hs_cnt[1]), 96'd64);
        chk("small_done_count", 96'(done_cnt[1]), 96'd2);
        chk("small_queue_empty", 96'(q.size()), 96'd0);
        q.delete();
        hand.delete();

        // Full raster frame with random backpressure and an enable gap
        sethand(1, 16'd0, 16'd4);      sethand(179, 16'd0, 16'd716);
        sethand(180, 16'd4, 16'd0);    sethand(57599, 16'd1276, 16'd716);
        push_exp(0, 0, 57600, 57600, 720);
        hs_cnt[0] = 0; done_cnt[0] = 0;
        mode = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        while (done_cnt[0] == 0 && i < 70000) begin
            out_ready = ($urandom_range(0, 15) != 0);
            enable    = !(i >= 1000 && i < 1005);
            tick();
            i++;
        end
        enable = 1'b1; out_ready = 1'b1;
        repeat (4) tick();
        chk("full_handshakes", 96'(hs_cnt[0]), 96'd57600);
        chk("full_done_count", 96'(done_cnt[0]), 96'd1);
        chk("full_queue_empty", 96'(q.size()), 96'd0);
        chk("idle_after_done", 96'({b_valid, b_busy, b_ix}), 96'({1'b0, 1'b0, 32'd57599}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
